// File: rtl/prng_pkg.sv
// Shared types and default constants for the range-limited PRNG.
// The FSM state enum is also used for the debug state output.
package prng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } prng_state_e;

    // Feedback taps on bits 13, 12, 11 and 1 of a 14-bit LFSR.
    localparam logic [13:0] PRNG_TAPS_DEFAULT = 14'h3802;
    // Reset value, and the recovery value if the register would go all-zero.
    localparam logic [13:0] PRNG_SEED_DEFAULT = 14'h32AF;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci-style LFSR with seed load and all-zero lockup guard.
// Priority: reset, then seed load, then step.
module lfsr_core #(
    parameter int                 WIDTH = 14,
    parameter logic [WIDTH-1:0]   TAPS  = 14'h3802,
    parameter logic [WIDTH-1:0]   SEED  = 14'h32AF
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Load,
    input  logic [WIDTH-1:0]  i_Seed,
    input  logic              i_Step,
    output logic [WIDTH-1:0]  o_State
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] shifted;
    logic             feedback;

    // Next-state selection: a zero seed or a zero shift result falls back to SEED.
    always_comb begin
        feedback = ^(state_q & TAPS);
        shifted  = {state_q[WIDTH-2:0], feedback};
        state_d  = state_q;
        if (i_Load) begin
            state_d = (i_Seed == '0) ? SEED : i_Seed;
        end else if (i_Step) begin
            state_d = (shifted == '0) ? SEED : shifted;
        end
    end

    // State register with synchronous reset to SEED.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_State = state_q;

endmodule

// File: rtl/prng_range.sv
// Range-limited random number generator using rejection sampling on an LFSR.
// A request walks IDLE -> STEP -> CHECK (-> STEP on rejection) -> DONE.
// After MAX_TRY rejections the result is 0 with o_Fallback set.
// Optional feature: define PRNG_FREE_RUN_EN to let the LFSR shift every
// cycle while IDLE, so request timing adds entropy.
// Handshake: i_RandNeed is a level request sampled only in IDLE; the result is
// valid for exactly one cycle when o_isRanDone is high, and o_RandNum holds
// its value until the next completion.
module prng_range
    import prng_pkg::*;
#(
    parameter int               WIDTH   = 14,
    parameter logic [WIDTH-1:0] TAPS    = PRNG_TAPS_DEFAULT,
    parameter logic [WIDTH-1:0] SEED    = PRNG_SEED_DEFAULT,
    parameter int               OUT_W   = 8,
    parameter int               MAX_TRY = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_RandNeed,
    input  logic [OUT_W-1:0]  i_Limit,
    input  logic              i_SeedLoad,
    input  logic [WIDTH-1:0]  i_Seed,
    output logic [OUT_W-1:0]  o_RandNum,
    output logic              o_isRanDone,
    output logic              o_Busy,
    output logic              o_Fallback,
    output logic [1:0]        o_DbgState
);

    localparam int CNT_W = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;

    prng_state_e      state_q;
    logic [CNT_W-1:0] try_q;
    logic [OUT_W-1:0] rand_q;
    logic             done_q;
    logic             busy_q;
    logic             fallback_q;

    logic [WIDTH-1:0] lfsr_state;
    logic [OUT_W-1:0] candidate;
    logic             accept;
    logic             lfsr_step;
    logic             last_try;

    assign candidate = lfsr_state[OUT_W-1:0];
    assign accept    = (i_Limit == '0) || (candidate < i_Limit);
    assign last_try  = !(32'(try_q) < (MAX_TRY - 1));

`ifdef PRNG_FREE_RUN_EN
    assign lfsr_step = (state_q == ST_STEP) || (state_q == ST_IDLE);
`else
    assign lfsr_step = (state_q == ST_STEP);
`endif

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Load  (i_SeedLoad),
        .i_Seed  (i_Seed),
        .i_Step  (lfsr_step),
        .o_State (lfsr_state)
    );

    // Request FSM, try counter and registered outputs; seed load aborts any request.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= ST_IDLE;
            try_q      <= '0;
            rand_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            fallback_q <= 1'b0;
        end else if (i_SeedLoad) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (i_RandNeed) begin
                        state_q <= ST_STEP;
                        busy_q  <= 1'b1;
                        try_q   <= '0;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (accept) begin
                        rand_q     <= candidate;
                        fallback_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end else if (!last_try) begin
                        try_q   <= try_q + 1'b1;
                        state_q <= ST_STEP;
                    end else begin
                        rand_q     <= '0;
                        fallback_q <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_RandNum   = rand_q;
    assign o_isRanDone = done_q;
    assign o_Busy      = busy_q;
    assign o_Fallback  = fallback_q;
    assign o_DbgState  = state_q;

endmodule

// File: tb/tb_prng_range.sv
// Self-checking bench for prng_range (default build, free-run disabled).
module tb_prng_range;

    localparam logic [13:0] SEED = 14'h32AF;

    logic        clk;
    logic        rst, need, seed_load;
    logic [7:0]  limit;
    logic [13:0] seed;
    logic [7:0]  rand_num;
    logic        done, busy, fallback;
    logic [1:0]  dbg_state;

    logic        rst2, need2, seed_load2;
    logic [7:0]  limit2;
    logic [13:0] seed2;
    logic [7:0]  rand_num2;
    logic        done2, busy2, fallback2;
    logic [1:0]  dbg_state2;

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [13:0] m_lfsr;

    prng_range dut (
        .i_Clk(clk), .i_Rst(rst), .i_RandNeed(need), .i_Limit(limit),
        .i_SeedLoad(seed_load), .i_Seed(seed), .o_RandNum(rand_num),
        .o_isRanDone(done), .o_Busy(busy), .o_Fallback(fallback),
        .o_DbgState(dbg_state)
    );

    prng_range #(.MAX_TRY(2)) dut2 (
        .i_Clk(clk), .i_Rst(rst2), .i_RandNeed(need2), .i_Limit(limit2),
        .i_SeedLoad(seed_load2), .i_Seed(seed2), .o_RandNum(rand_num2),
        .o_isRanDone(done2), .o_Busy(busy2), .o_Fallback(fallback2),
        .o_DbgState(dbg_state2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: shift left, append parity of bits 13,12,11,1; zero maps to SEED.
    function automatic logic [13:0] mdl_next(input logic [13:0] s);
        int v;
        int p;
        p = (s[13] ^ s[12] ^ s[11] ^ s[1]) ? 1 : 0;
        v = ((int'(s) * 2) % 16384) + p;
        if (v == 0) return SEED;
        return 14'(v);
    endfunction

    // Reference for one full request: up to max_try draws, first in-range wins.
    task automatic mdl_req(input logic [13:0] s_in, input logic [7:0] lim, input int max_try,
                           output logic [13:0] s_out, output logic [7:0] val,
                           output logic fb, output int rej);
        logic [13:0] s;
        int cand;
        s   = s_in;
        val = 8'd0;
        fb  = 1'b1;
        rej = max_try - 1;
        for (int t = 0; t < max_try; t++) begin
            s = mdl_next(s);
            cand = int'(s) % 256;
            if (lim == 8'd0 || cand < int'(lim)) begin
                val = 8'(cand);
                fb  = 1'b0;
                rej = t;
                break;
            end
        end
        s_out = s;
    endtask

    // Issue one request on dut and observe the completion (edges = -1 on timeout).
    task automatic req_obs(input logic [7:0] lim, output logic [7:0] val,
                           output logic fb, output int edges);
        limit = lim;
        need  = 1'b1;
        tick();
        need  = 1'b0;
        edges = -1;
        val   = 8'd0;
        fb    = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (done) begin
                edges = k;
                val   = rand_num;
                fb    = fallback;
                break;
            end
        end
        if (edges > 0) check("busy_at_done", 32'(busy), 32'd1);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_back_idle", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [7:0] limit;
        logic [7:0] exp_val;
        logic       exp_fb;
        int         exp_edges;
    } vec_t;

    initial begin
        vec_t        vecs[4];
        logic [7:0]  v, mv;
        logic        f, mf;
        int          e, mr, k, pulses;
        logic [13:0] ns;

        vecs[0] = '{limit: 8'd200, exp_val: 8'd95,  exp_fb: 1'b0, exp_edges: 2};
        vecs[1] = '{limit: 8'd150, exp_val: 8'd124, exp_fb: 1'b0, exp_edges: 4};
        vecs[2] = '{limit: 8'd0,   exp_val: 8'd249, exp_fb: 1'b0, exp_edges: 2};
        vecs[3] = '{limit: 8'd250, exp_val: 8'd242, exp_fb: 1'b0, exp_edges: 2};

        rst = 1'b1; need = 1'b0; seed_load = 1'b0; limit = 8'd0; seed = 14'd0;
        rst2 = 1'b1; need2 = 1'b0; seed_load2 = 1'b0; limit2 = 8'd0; seed2 = 14'd0;
        tick(); tick();
        rst = 1'b0; rst2 = 1'b0;
        m_lfsr = SEED;

        check("rst_randnum", 32'(rand_num), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fallback", 32'(fallback), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_lfsr", 32'(dut.lfsr_state), 32'h32AF);

        // Directed table from reset
        for (int i = 0; i < 4; i++) begin
            req_obs(vecs[i].limit, v, f, e);
            mdl_req(m_lfsr, vecs[i].limit, 8, ns, mv, mf, mr);
            m_lfsr = ns;
            check($sformatf("vec%0d_val", i), 32'(v), 32'(vecs[i].exp_val));
            check($sformatf("vec%0d_fb", i), 32'(f), 32'(vecs[i].exp_fb));
            check($sformatf("vec%0d_edges", i), 32'(e), 32'(vecs[i].exp_edges));
            check($sformatf("vec%0d_model", i), 32'(v), 32'(mv));
            if (i == 0) check("vec0_lfsr", 32'(dut.lfsr_state), 32'h255F);
            if (i == 1) check("vec1_lfsr", 32'(dut.lfsr_state), 32'h157C);
        end

        // MAX_TRY=2 instance: two rejections then fallback
        limit2 = 8'd1;
        need2  = 1'b1;
        tick();
        need2  = 1'b0;
        e = -1;
        for (int k2 = 1; k2 <= 20; k2++) begin
            tick();
            if (done2) begin
                e = k2;
                break;
            end
        end
        check("fb2_edges", 32'(e), 32'd4);
        check("fb2_val", 32'(rand_num2), 32'd0);
        check("fb2_flag", 32'(fallback2), 32'd1);
        tick();
        check("fb2_done_low", 32'(done2), 32'd0);

        // Limit changed between CHECK cycles: new limit applies at the next CHECK
        rst = 1'b1; tick(); rst = 1'b0;
        limit = 8'd1; need = 1'b1;
        tick();
        need = 1'b0;
        tick();
        tick();
        limit = 8'd0;
        tick();
        check("midlim_not_done", 32'(done), 32'd0);
        tick();
        check("midlim_done", 32'(done), 32'd1);
        check("midlim_val", 32'(rand_num), 32'd190);
        check("midlim_fb", 32'(fallback), 32'd0);
        tick();

        // Seed load of zero substitutes SEED
        seed_load = 1'b1; seed = 14'd0;
        tick();
        seed_load = 1'b0;
        check("seed0_lfsr", 32'(dut.lfsr_state), 32'h32AF);

        // Seed load during CHECK aborts silently
        limit = 8'd0; need = 1'b1;
        tick();
        need = 1'b0;
        tick();
        check("abort_in_check", 32'(dbg_state), 32'd2);
        seed_load = 1'b1; seed = 14'h1234;
        tick();
        seed_load = 1'b0;
        check("abort_state", 32'(dbg_state), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_val_held", 32'(rand_num), 32'd190);
        check("abort_lfsr", 32'(dut.lfsr_state), 32'h1234);
        pulses = 0;
        for (int k3 = 0; k3 < 4; k3++) begin
            if (done) pulses++;
            tick();
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);

        // Reset during STEP aborts silently
        need = 1'b1;
        tick();
        need = 1'b0;
        check("rst_step_state", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_step_idle", 32'(dbg_state), 32'd0);
        check("rst_step_val", 32'(rand_num), 32'd0);
        check("rst_step_lfsr", 32'(dut.lfsr_state), 32'h32AF);
        check("rst_step_done", 32'(done), 32'd0);
        m_lfsr = SEED;

        // Held request: exactly one pulse per IDLE entry
        limit = 8'd100; need = 1'b1;
        for (int p = 0; p < 5; p++) begin
            mdl_req(m_lfsr, 8'd100, 8, ns, mv, mf, mr);
            m_lfsr = ns;
            k = -1;
            for (int k4 = 1; k4 <= 40; k4++) begin
                tick();
                if (done) begin
                    k = k4;
                    break;
                end
            end
            if (p == 4) need = 1'b0;
            check($sformatf("hold%0d_val", p), 32'(rand_num), 32'(mv));
            check($sformatf("hold%0d_fb", p), 32'(fallback), 32'(mf));
            check($sformatf("hold%0d_gap", p), 32'(k), 32'((p == 0) ? 3 + 2 * mr : 4 + 2 * mr));
        end
        tick(); tick();

        // Randomized requests with occasional reseeding
        for (int r = 0; r < 60; r++) begin
            logic [7:0] lim;
            if ($urandom_range(0, 7) == 0) begin
                seed = ($urandom_range(0, 3) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
                seed_load = 1'b1;
                tick();
                seed_load = 1'b0;
                m_lfsr = (seed == 14'd0) ? SEED : seed;
            end
            lim = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            req_obs(lim, v, f, e);
            mdl_req(m_lfsr, lim, 8, ns, mv, mf, mr);
            m_lfsr = ns;
            check($sformatf("rnd%0d_val", r), 32'(v), 32'(mv));
            check($sformatf("rnd%0d_fb", r), 32'(f), 32'(mf));
            check($sformatf("rnd%0d_edges", r), 32'(e), 32'(2 + 2 * mr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
